// File: rtl/timer_pkg.sv
// Shared types and BCD helper for the elapsed-seconds timer.
// Latency: n/a (package only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int DIGIT_W     = 4;
    localparam int SEC_PER_MIN = 60;
    localparam int MAX_SEC     = 599;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } bcd_time_t;

    // One-second BCD increment with m:ss carries; 9:59 saturates.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min_ones == 4'd9 && t.sec_tens == 4'd5 && t.sec_ones == 4'd9) begin
            r = t;
        end else if (t.sec_ones != 4'd9) begin
            r.sec_ones = t.sec_ones + 4'd1;
        end else begin
            r.sec_ones = 4'd0;
            if (t.sec_tens != 4'd5) begin
                r.sec_tens = t.sec_tens + 4'd1;
            end else begin
                r.sec_tens = 4'd0;
                r.min_ones = t.min_ones + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles, holds while disabled.
// Latency: tick asserted combinationally in the cycle the count sits at TICK_DIV-1.
// Backpressure: none; en gates counting, sync_clr zeroes and suppresses the tick.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !sync_clr && (cnt == LAST);

endmodule

// File: rtl/sec_timer_core.sv
// Elapsed-seconds timer with BCD m:ss digits, min and timeout flags for the LED stage.
// Latency: digits and flags update one clk after the prescaler tick; all outputs registered.
// Backpressure: none; start toggles run/pause, clear returns to IDLE and wins over everything.
module sec_timer_core
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int LIMIT_SEC = 90
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    output logic [3:0]   sec_ones,
    output logic [3:0]   sec_tens,
    output logic [3:0]   min_ones,
    output logic         running,
    output logic         min,
    output logic         timeout
);

    localparam logic [9:0] LIMIT = 10'(LIMIT_SEC);

    state_t    state;
    bcd_time_t tm;
    bcd_time_t tm_next;
    logic [9:0] elapsed;
    logic       tick;
    logic       presc_clr;

    // Zero the prescaler on IDLE->RUN so the first second is a full period.
    assign presc_clr = clear || (state == IDLE && start);
    assign tm_next   = bcd_inc(tm);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == RUN),
        .sync_clr (presc_clr),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tm      <= '0;
            elapsed <= '0;
            running <= 1'b0;
            min     <= 1'b0;
            timeout <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            tm      <= '0;
            elapsed <= '0;
            running <= 1'b0;
            min     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: begin
                    if (tick) begin
                        tm      <= tm_next;
                        elapsed <= elapsed + 10'd1;
                        min     <= (tm_next.min_ones != 4'd0);
                    end
                    // Reaching the limit takes priority over a coincident pause.
                    if (tick && (elapsed + 10'd1 == LIMIT)) begin
                        state   <= DONE;
                        running <= 1'b0;
                        timeout <= 1'b1;
                    end else if (start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: if (start) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sec_ones = tm.sec_ones;
    assign sec_tens = tm.sec_tens;
    assign min_ones = tm.min_ones;

endmodule

// File: tb/tb_sec_timer_core.sv
// Directed scoreboard bench for sec_timer_core: a fast-tick instance with a 65 s limit
// and one with a 599 s limit for the full carry chain.
module tb_sec_timer_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;

    logic [3:0] a_so, a_st, a_mo, b_so, b_st, b_mo;
    logic       a_run, a_min, a_to, b_run, b_min, b_to;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       mn;
        logic       to;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sec_timer_core #(.TICK_DIV(4), .LIMIT_SEC(65)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo),
        .running(a_run), .min(a_min), .timeout(a_to)
    );

    sec_timer_core #(.TICK_DIV(4), .LIMIT_SEC(599)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo),
        .running(b_run), .min(b_min), .timeout(b_to)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (m,t,o,run,min,timeout)", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int m, input int t, input int o,
                            input bit run, input bit mn, input bit to);
        obs_t e;
        e.m = 4'(m); e.t = 4'(t); e.o = 4'(o);
        e.run = run; e.mn = mn; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag, input bit use_b);
        obs_t o;
        obs_t e;
        if (use_b) o = {b_mo, b_st, b_so, b_run, b_min, b_to};
        else       o = {a_mo, a_st, a_so, a_run, a_min, a_to};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", tag, o);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, 32'(o), 32'(e));
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit s, input bit c);
        start = s;
        clear = c;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        wait_n(3);
        push_exp(0, 0, 0, 0, 0, 0); pop_check("reset_a", 1'b0);
        push_exp(0, 0, 0, 0, 0, 0); pop_check("reset_b", 1'b1);
        rst_n = 1'b1;
        wait_n(1);

        // Basic counting up to the 65 s limit
        pulse(1'b1, 1'b0);
        push_exp(0, 0, 0, 1, 0, 0); pop_check("start_run", 1'b0);
        wait_n(4);
        push_exp(0, 0, 1, 1, 0, 0); pop_check("first_sec", 1'b0);
        wait_n(36);
        push_exp(0, 1, 0, 1, 0, 0); pop_check("ten_sec", 1'b0);
        wait_n(199);
        push_exp(0, 5, 9, 1, 0, 0); pop_check("at_0_59", 1'b0);
        wait_n(1);
        push_exp(1, 0, 0, 1, 1, 0); pop_check("min_at_1_00", 1'b0);
        wait_n(19);
        push_exp(1, 0, 4, 1, 1, 0); pop_check("at_1_04", 1'b0);
        wait_n(1);
        push_exp(1, 0, 5, 0, 1, 1); pop_check("timeout_1_05", 1'b0);
        wait_n(20);
        push_exp(1, 0, 5, 0, 1, 1); pop_check("done_hold", 1'b0);
        pulse(1'b1, 1'b0);
        wait_n(8);
        push_exp(1, 0, 5, 0, 1, 1); pop_check("done_start_ignored", 1'b0);
        pulse(1'b0, 1'b1);
        push_exp(0, 0, 0, 0, 0, 0); pop_check("clear_done", 1'b0);

        // Pause preserves the fractional second
        pulse(1'b1, 1'b0);
        wait_n(12);
        push_exp(0, 0, 3, 1, 0, 0); pop_check("at_0_03", 1'b0);
        wait_n(2);
        pulse(1'b1, 1'b0);
        push_exp(0, 0, 3, 0, 0, 0); pop_check("paused", 1'b0);
        wait_n(50);
        push_exp(0, 0, 3, 0, 0, 0); pop_check("pause_hold", 1'b0);
        pulse(1'b1, 1'b0);
        push_exp(0, 0, 3, 1, 0, 0); pop_check("resumed", 1'b0);
        wait_n(1);
        push_exp(0, 0, 4, 1, 0, 0); pop_check("resume_tick", 1'b0);

        // Asynchronous reset mid-count at 1:02
        wait_n(232);
        push_exp(1, 0, 2, 1, 1, 0); pop_check("at_1_02", 1'b0);
        rst_n = 1'b0;
        #1;
        push_exp(0, 0, 0, 0, 0, 0); pop_check("async_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(1);
        pulse(1'b1, 1'b0);
        wait_n(4);
        push_exp(0, 0, 1, 1, 0, 0); pop_check("restart_0_01", 1'b0);

        // clear beats a simultaneous start
        wait_n(2);
        pulse(1'b1, 1'b1);
        push_exp(0, 0, 0, 0, 0, 0); pop_check("clear_and_start", 1'b0);
        wait_n(8);
        push_exp(0, 0, 0, 0, 0, 0); pop_check("stay_idle", 1'b0);

        // Full carry chain on the 599 s instance
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        push_exp(0, 0, 0, 1, 0, 0); pop_check("b_start", 1'b1);
        wait_n(236);
        push_exp(0, 5, 9, 1, 0, 0); pop_check("b_0_59", 1'b1);
        wait_n(4);
        push_exp(1, 0, 0, 1, 1, 0); pop_check("b_1_00", 1'b1);
        wait_n(1196);
        push_exp(5, 5, 9, 1, 1, 0); pop_check("b_5_59", 1'b1);
        wait_n(4);
        push_exp(6, 0, 0, 1, 1, 0); pop_check("b_6_00", 1'b1);
        wait_n(952);
        push_exp(9, 5, 8, 1, 1, 0); pop_check("b_9_58", 1'b1);
        wait_n(4);
        push_exp(9, 5, 9, 0, 1, 1); pop_check("b_timeout_9_59", 1'b1);
        wait_n(8);
        push_exp(9, 5, 9, 0, 1, 1); pop_check("b_hold_9_59", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
